// File: rtl/fwd_hazard_ctrl.sv
// Data-hazard controller for the 5-stage pipeline: EX/MEM operand forwarding,
// load-use and MDU-busy stall generation, and a saturating stall counter.
module fwd_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_uses_rs,
  input  logic              ifid_uses_rt,
  input  logic              ifid_uses_mdu,
  input  logic [REG_AW-1:0] idex_rs,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic              idex_mem_read,
  input  logic              idex_mdu_start,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [REG_AW-1:0] exmem_rt,
  input  logic              exmem_reg_write,
  input  logic              exmem_mem_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  output logic [1:0]        alua_sel,
  output logic [1:0]        alub_sel,
  output logic              store_sel,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              idex_flush,
  output logic              mdu_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int CW = $clog2(MDU_LAT);

  typedef enum logic {RUN, MDU} mduState_t;

  mduState_t        stateReg, stateNext;
  logic [CW-1:0]    countReg, countNext;
  logic [CNT_W-1:0] stallCntReg;
  logic             loadUse, mduHazard, stall;

  logic [REG_AW-1:0] exSrc  [2];
  logic [1:0]        fwdSel [2];

  assign exSrc[0] = idex_rs;
  assign exSrc[1] = idex_rt;

  // The younger producer (EX/MEM) shadows the older one (WB).
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic exHit, wbHit;
    assign exHit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == exSrc[gi]);
    assign wbHit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == exSrc[gi]);
    assign fwdSel[gi] = exHit ? 2'b10 : (wbHit ? 2'b01 : 2'b00);
  end

  assign alua_sel  = fwdSel[0];
  assign alub_sel  = fwdSel[1];
  assign store_sel = exmem_mem_write && memwb_reg_write && (memwb_rd != '0)
                     && (memwb_rd == exmem_rt);

  assign loadUse = idex_mem_read && (idex_rt != '0) &&
                   ((ifid_uses_rs && (ifid_rs == idex_rt)) ||
                    (ifid_uses_rt && (ifid_rt == idex_rt)));
  assign mduHazard = (stateReg == MDU) && ifid_uses_mdu;
  assign stall     = loadUse || mduHazard;

  assign pc_hold    = stall;
  assign ifid_hold  = stall;
  assign idex_flush = stall;
  assign mdu_busy   = (stateReg == MDU);
  assign stall_cnt  = stallCntReg;

  always_comb begin
    stateNext = stateReg;
    countNext = countReg;
    case (stateReg)
      RUN: begin
        if (idex_mdu_start) begin
          stateNext = MDU;
          countNext = CW'(MDU_LAT - 1);
        end
      end
      MDU: begin
        if (countReg == '0) begin
          stateNext = RUN;
        end else begin
          countNext = countReg - CW'(1);
        end
      end
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg    <= RUN;
      countReg    <= '0;
      stallCntReg <= '0;
    end else begin
      stateReg <= stateNext;
      countReg <= countNext;
      if (stall && (stallCntReg != '1)) begin
        stallCntReg <= stallCntReg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench: directed hazard scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the hazard rules.
module tb_fwd_hazard_ctrl;

  localparam int REG_AW  = 5;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] ifid_rs, ifid_rt, idex_rs, idex_rt;
  logic [REG_AW-1:0] exmem_rd, exmem_rt, memwb_rd;
  logic              ifid_uses_rs, ifid_uses_rt, ifid_uses_mdu;
  logic              idex_mem_read, idex_mdu_start;
  logic              exmem_reg_write, exmem_mem_write, memwb_reg_write;
  logic [1:0]        alua_sel, alub_sel;
  logic              store_sel, pc_hold, ifid_hold, idex_flush, mdu_busy;
  logic [CNT_W-1:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  // Model state: cycles of MDU busy still owed, and stall cycles seen.
  int busyLeft   = 0;
  int stallCount = 0;
  bit modelValid = 0;

  fwd_hazard_ctrl #(.REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt),
    .ifid_uses_mdu(ifid_uses_mdu),
    .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_mem_read(idex_mem_read), .idex_mdu_start(idex_mdu_start),
    .exmem_rd(exmem_rd), .exmem_rt(exmem_rt),
    .exmem_reg_write(exmem_reg_write), .exmem_mem_write(exmem_mem_write),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
    .alua_sel(alua_sel), .alub_sel(alub_sel), .store_sel(store_sel),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_flush(idex_flush),
    .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int expFwd(input logic [REG_AW-1:0] src);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == src) return 2;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == src) return 1;
    return 0;
  endfunction

  function automatic int expStore();
    return (exmem_mem_write && memwb_reg_write && memwb_rd != 0 &&
            memwb_rd == exmem_rt) ? 1 : 0;
  endfunction

  function automatic int expStall();
    int lu, mh;
    lu = (idex_mem_read && idex_rt != 0 &&
          ((ifid_uses_rs && ifid_rs == idex_rt) ||
           (ifid_uses_rt && ifid_rt == idex_rt))) ? 1 : 0;
    mh = (busyLeft > 0 && ifid_uses_mdu) ? 1 : 0;
    return (lu || mh) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      busyLeft   = 0;
      stallCount = 0;
      modelValid = 1;
    end else if (modelValid) begin
      if (expStall() == 1 && stallCount < CNT_MAX) stallCount = stallCount + 1;
      if (busyLeft > 0) busyLeft = busyLeft - 1;
      else if (idex_mdu_start) busyLeft = MDU_LAT;
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      chk("alua_sel",   int'(alua_sel),   expFwd(idex_rs));
      chk("alub_sel",   int'(alub_sel),   expFwd(idex_rt));
      chk("store_sel",  int'(store_sel),  expStore());
      chk("pc_hold",    int'(pc_hold),    expStall());
      chk("ifid_hold",  int'(ifid_hold),  expStall());
      chk("idex_flush", int'(idex_flush), expStall());
      chk("mdu_busy",   int'(mdu_busy),   (busyLeft > 0) ? 1 : 0);
      chk("stall_cnt",  int'(stall_cnt),  stallCount);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clearInputs();
    ifid_rs = 0; ifid_rt = 0; idex_rs = 0; idex_rt = 0;
    exmem_rd = 0; exmem_rt = 0; memwb_rd = 0;
    ifid_uses_rs = 0; ifid_uses_rt = 0; ifid_uses_mdu = 0;
    idex_mem_read = 0; idex_mdu_start = 0;
    exmem_reg_write = 0; exmem_mem_write = 0; memwb_reg_write = 0;
  endtask

  task automatic resetDut();
    clearInputs();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  initial begin
    clearInputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    #1;
    chk("reset_busy", int'(mdu_busy), 0);
    chk("reset_cnt",  int'(stall_cnt), 0);
    step();

    // Double hazard: EX/MEM beats WB, $0 never forwards
    exmem_reg_write = 1; exmem_rd = 8; memwb_reg_write = 1; memwb_rd = 8;
    idex_rs = 8; idex_rt = 8;
    #1; chk("dbl_a_ex", int'(alua_sel), 2); chk("dbl_b_ex", int'(alub_sel), 2);
    step();
    exmem_reg_write = 0;
    #1; chk("dbl_a_wb", int'(alua_sel), 1); chk("dbl_b_wb", int'(alub_sel), 1);
    step();
    exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0; idex_rs = 0; idex_rt = 0;
    #1; chk("dbl_a_r0", int'(alua_sel), 0); chk("dbl_b_r0", int'(alub_sel), 0);
    step();
    clearInputs();

    // Store-data forwarding
    exmem_mem_write = 1; exmem_rt = 5; memwb_reg_write = 1; memwb_rd = 5;
    #1; chk("store_hit", int'(store_sel), 1);
    step();
    memwb_rd = 6;
    #1; chk("store_miss", int'(store_sel), 0);
    step();
    clearInputs();

    // Load-use: one stall cycle, counter +1; load to $0 is harmless
    resetDut();
    idex_mem_read = 1; idex_rt = 3; ifid_uses_rt = 1; ifid_rt = 3;
    #1; chk("lu_hold", int'(pc_hold), 1); chk("lu_flush", int'(idex_flush), 1);
    step();
    clearInputs();
    #1; chk("lu_cnt", int'(stall_cnt), 1); chk("lu_release", int'(pc_hold), 0);
    idex_mem_read = 1; idex_rt = 0; ifid_uses_rt = 1; ifid_rt = 0;
    #1; chk("lu_r0", int'(pc_hold), 0);
    step();
    clearInputs();

    // MDU busy for MDU_LAT cycles with a waiting MDU instruction in ID
    resetDut();
    idex_mdu_start = 1; ifid_uses_mdu = 1;
    step();
    idex_mdu_start = 0;
    for (int i = 0; i < MDU_LAT; i++) begin
      #1; chk("mdu_busy_on", int'(mdu_busy), 1); chk("mdu_stall", int'(pc_hold), 1);
      step();
    end
    #1; chk("mdu_busy_off", int'(mdu_busy), 0); chk("mdu_cnt", int'(stall_cnt), 4);
    step();

    // MDU without a dependent instruction: busy but no stall
    resetDut();
    idex_mdu_start = 1;
    step();
    idex_mdu_start = 0;
    for (int i = 0; i < MDU_LAT; i++) step();
    #1; chk("mdu_nostall_cnt", int'(stall_cnt), 0);
    step();

    // Simultaneous load-use and MDU hazard, then reset mid-operation
    resetDut();
    idex_mdu_start = 1; ifid_uses_mdu = 1;
    step();
    idex_mdu_start = 0;
    idex_mem_read = 1; idex_rt = 4; ifid_uses_rs = 1; ifid_rs = 4;
    #1; chk("both_stall", int'(pc_hold), 1);
    step();
    #1; chk("both_cnt", int'(stall_cnt), 1);
    rst_n = 0;
    step();
    rst_n = 1;
    clearInputs();
    #1; chk("midrst_busy", int'(mdu_busy), 0); chk("midrst_cnt", int'(stall_cnt), 0);
    step();

    // Saturation at 2^CNT_W-1
    resetDut();
    idex_mem_read = 1; idex_rt = 7; ifid_uses_rt = 1; ifid_rt = 7;
    for (int i = 0; i < 10; i++) step();
    #1; chk("sat_cnt", int'(stall_cnt), 7);
    step();
    clearInputs();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n           = ($urandom_range(0, 49) != 0);
      ifid_rs         = REG_AW'($urandom_range(0, 3));
      ifid_rt         = REG_AW'($urandom_range(0, 3));
      idex_rs         = REG_AW'($urandom_range(0, 3));
      idex_rt         = REG_AW'($urandom_range(0, 3));
      exmem_rd        = REG_AW'($urandom_range(0, 3));
      exmem_rt        = REG_AW'($urandom_range(0, 3));
      memwb_rd        = REG_AW'($urandom_range(0, 3));
      ifid_uses_rs    = 1'($urandom_range(0, 1));
      ifid_uses_rt    = 1'($urandom_range(0, 1));
      ifid_uses_mdu   = 1'($urandom_range(0, 1));
      idex_mem_read   = ($urandom_range(0, 3) == 0);
      idex_mdu_start  = ($urandom_range(0, 5) == 0);
      exmem_reg_write = 1'($urandom_range(0, 1));
      exmem_mem_write = 1'($urandom_range(0, 1));
      memwb_reg_write = 1'($urandom_range(0, 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
